eval_sram_to_sram_sequencer: RTL and testbench



---
 rtl/eval_sram_to_sram_sequencer_if.sv | 38 +++
 rtl/eval_sram_to_sram_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_eval_sram_to_sram_sequencer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eval_sram_to_sram_sequencer_if.sv
// AXI4-Lite register bus used to program the SRAM-to-SRAM sequencer.
// The master modport is the PS side and the slave modport is the sequencer.
interface eval_sram_to_sram_sequencer_if #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_BITS-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_BITS-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/eval_sram_to_sram_sequencer.sv
// AXI4-Lite programmed copy engine: streams one word per cycle from a source
// SRAM region into a destination region, with start/abort, status and cycle count.
module eval_sram_to_sram_sequencer #(
    parameter int          AXI4L_ADDR_BITS   = 40,
    parameter int          AXI4L_DATA_BITS   = 64,
    parameter int          SRAM_ADDR_BITS    = 10,
    parameter int          SRAM_DATA_BITS    = 64,
    parameter int          SRAM_READ_LATENCY = 2,
    parameter logic [63:0] CORE_ID           = 64'h5352_4D32_5345_5130
) (
    input  logic                          s_axi4l_aclk,
    input  logic                          s_axi4l_aresetn,
    eval_sram_to_sram_sequencer_if.slave  s_axi4l,
    output logic                          sram_rd_en,
    output logic [SRAM_ADDR_BITS-1:0]     sram_rd_addr,
    input  logic [SRAM_DATA_BITS-1:0]     sram_rd_data,
    output logic                          sram_wr_en,
    output logic [SRAM_ADDR_BITS-1:0]     sram_wr_addr,
    output logic [SRAM_DATA_BITS-1:0]     sram_wr_data,
    output logic                          busy,
    output logic                          irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [SRAM_READ_LATENCY-1:0] PIPE_OLDEST =
        SRAM_READ_LATENCY'(1) << (SRAM_READ_LATENCY - 1);

    // Bus-side state
    logic                        awready_r;
    logic                        bvalid_r;
    logic                        arready_r;
    logic                        rvalid_r;
    logic [AXI4L_DATA_BITS-1:0]  rdata_r;
    logic [AXI4L_DATA_BITS-1:0]  rdata_mux_s;
    logic [AXI4L_ADDR_BITS-1:0]  awaddr_s;
    logic [AXI4L_ADDR_BITS-1:0]  araddr_s;
    logic [2:0]                  wr_sel_s;
    logic [2:0]                  rd_sel_s;
    logic                        wr_hs_s;
    logic                        rd_hs_s;
    logic                        ctl_wr_s;
    logic                        start_s;
    logic                        abort_s;
    logic                        done_clr_s;
    logic                        cfg_wr_s;
    logic                        unused_s;

    // Engine state
    state_t                      state_r;
    logic [SRAM_ADDR_BITS-1:0]   src_r;
    logic [SRAM_ADDR_BITS-1:0]   dst_r;
    logic [31:0]                 len_r;
    logic [31:0]                 cycles_r;
    logic                        done_r;
    logic                        busy_r;
    logic                        rd_en_r;
    logic [SRAM_ADDR_BITS-1:0]   rd_addr_r;
    logic [SRAM_ADDR_BITS-1:0]   rd_dst_r;
    logic [31:0]                 remain_r;
    logic [SRAM_READ_LATENCY-1:0] pipe_v_r;
    logic [SRAM_ADDR_BITS-1:0]   pipe_addr_r [SRAM_READ_LATENCY];
    logic                        drain_done_s;

    assign awaddr_s   = s_axi4l.awaddr;
    assign araddr_s   = s_axi4l.araddr;
    assign wr_sel_s   = awaddr_s[5:3];
    assign rd_sel_s   = araddr_s[5:3];
    assign wr_hs_s    = awready_r && s_axi4l.awvalid && s_axi4l.wvalid;
    assign rd_hs_s    = arready_r && s_axi4l.arvalid;
    assign ctl_wr_s   = wr_hs_s && (wr_sel_s == 3'd1);
    // Abort dominates a start carried in the same CTL write
    assign abort_s    = ctl_wr_s && s_axi4l.wdata[1];
    assign start_s    = ctl_wr_s && s_axi4l.wdata[0] && !s_axi4l.wdata[1];
    assign done_clr_s = wr_hs_s && (wr_sel_s == 3'd2) && s_axi4l.wdata[1];
    assign cfg_wr_s   = wr_hs_s && (state_r == ST_IDLE);

    // The pipe is empty after this edge when nothing younger than the oldest stage remains
    assign drain_done_s = !rd_en_r && ((pipe_v_r & ~PIPE_OLDEST) == '0);

    assign unused_s = ^{awaddr_s, araddr_s, s_axi4l.awprot, s_axi4l.arprot,
                        s_axi4l.wstrb, s_axi4l.wdata};

    assign s_axi4l.awready = awready_r;
    assign s_axi4l.wready  = awready_r;
    assign s_axi4l.bvalid  = bvalid_r;
    assign s_axi4l.bresp   = 2'b00;
    assign s_axi4l.arready = arready_r;
    assign s_axi4l.rvalid  = rvalid_r;
    assign s_axi4l.rdata   = rdata_r;
    assign s_axi4l.rresp   = 2'b00;

    assign sram_rd_en   = rd_en_r;
    assign sram_rd_addr = rd_addr_r;
    assign sram_wr_en   = pipe_v_r[SRAM_READ_LATENCY-1];
    assign sram_wr_addr = pipe_addr_r[SRAM_READ_LATENCY-1];
    assign sram_wr_data = sram_rd_data;
    assign busy         = busy_r;
    assign irq          = done_r;

    // Register readback mux
    always_comb begin
        rdata_mux_s = '0;
        case (rd_sel_s)
            3'd0:    rdata_mux_s = AXI4L_DATA_BITS'(CORE_ID);
            3'd2:    rdata_mux_s = AXI4L_DATA_BITS'({done_r, busy_r});
            3'd3:    rdata_mux_s = AXI4L_DATA_BITS'(src_r);
            3'd4:    rdata_mux_s = AXI4L_DATA_BITS'(dst_r);
            3'd5:    rdata_mux_s = AXI4L_DATA_BITS'(len_r);
            3'd6:    rdata_mux_s = AXI4L_DATA_BITS'(cycles_r);
            default: rdata_mux_s = '0;
        endcase
    end

    // AXI4-Lite handshakes and read-data capture
    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
        end else begin
            awready_r <= s_axi4l.awvalid && s_axi4l.wvalid && !bvalid_r && !awready_r;
            arready_r <= s_axi4l.arvalid && !rvalid_r && !arready_r;
            if (wr_hs_s) begin
                bvalid_r <= 1'b1;
            end else if (bvalid_r && s_axi4l.bready) begin
                bvalid_r <= 1'b0;
            end
            if (rd_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rdata_mux_s;
            end else if (rvalid_r && s_axi4l.rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Transfer FSM, configuration and status registers, in-flight pipe
    always_ff @(posedge s_axi4l_aclk or negedge s_axi4l_aresetn) begin
        if (!s_axi4l_aresetn) begin
            state_r   <= ST_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= 32'd0;
            cycles_r  <= 32'd0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
            rd_dst_r  <= '0;
            remain_r  <= 32'd0;
            pipe_v_r  <= '0;
            for (int i = 0; i < SRAM_READ_LATENCY; i++) begin
                pipe_addr_r[i] <= '0;
            end
        end else begin
            pipe_v_r[0]    <= rd_en_r;
            pipe_addr_r[0] <= rd_dst_r;
            for (int i = 1; i < SRAM_READ_LATENCY; i++) begin
                pipe_v_r[i]    <= pipe_v_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
            end

            if (cfg_wr_s) begin
                case (wr_sel_s)
                    3'd3:    src_r <= s_axi4l.wdata[SRAM_ADDR_BITS-1:0];
                    3'd4:    dst_r <= s_axi4l.wdata[SRAM_ADDR_BITS-1:0];
                    3'd5:    len_r <= s_axi4l.wdata[31:0];
                    default: ;
                endcase
            end

            if (done_clr_s) begin
                done_r <= 1'b0;
            end
            if (busy_r && (cycles_r != 32'hFFFF_FFFF)) begin
                cycles_r <= cycles_r + 32'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        cycles_r <= 32'd0;
                        if (len_r != 32'd0) begin
                            state_r   <= ST_RUN;
                            busy_r    <= 1'b1;
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= src_r;
                            rd_dst_r  <= dst_r;
                            remain_r  <= len_r - 32'd1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_s || (remain_r == 32'd0)) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_addr_r <= rd_addr_r + SRAM_ADDR_BITS'(1);
                        rd_dst_r  <= rd_dst_r + SRAM_ADDR_BITS'(1);
                        remain_r  <= remain_r - 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    rd_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eval_sram_to_sram_sequencer.sv
// Scoreboard bench for eval_sram_to_sram_sequencer: expected SRAM reads/writes
// are queued with their cycle offsets at start and matched as the DUT emits them.
module tb_eval_sram_to_sram_sequencer;

    localparam int L = 2;
    localparam logic [39:0] A_ID     = 40'h00;
    localparam logic [39:0] A_CTL    = 40'h08;
    localparam logic [39:0] A_STATUS = 40'h10;
    localparam logic [39:0] A_SRC    = 40'h18;
    localparam logic [39:0] A_DST    = 40'h20;
    localparam logic [39:0] A_LEN    = 40'h28;
    localparam logic [39:0] A_CYCLES = 40'h30;

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
        int          offset;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sram_rd_en;
    logic [9:0]  sram_rd_addr;
    logic [63:0] sram_rd_data;
    logic        sram_wr_en;
    logic [9:0]  sram_wr_addr;
    logic [63:0] sram_wr_data;
    logic        busy;
    logic        irq;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    exp_t rd_q[$];
    exp_t wr_q[$];
    exp_t mon_rd_e;
    exp_t mon_wr_e;
    logic [63:0] rd_pipe [L];

    eval_sram_to_sram_sequencer_if #(.ADDR_BITS(40), .DATA_BITS(64)) axi ();

    eval_sram_to_sram_sequencer dut (
        .s_axi4l_aclk    (clk),
        .s_axi4l_aresetn (rst_n),
        .s_axi4l         (axi),
        .sram_rd_en      (sram_rd_en),
        .sram_rd_addr    (sram_rd_addr),
        .sram_rd_data    (sram_rd_data),
        .sram_wr_en      (sram_wr_en),
        .sram_wr_addr    (sram_wr_addr),
        .sram_wr_data    (sram_wr_data),
        .busy            (busy),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] word_at(input logic [9:0] a);
        return {32'hC0DE_0000 | {22'd0, a}, 32'h1234_5678 ^ {a, 22'd0}};
    endfunction

    // Source SRAM model with two-cycle read latency
    always @(posedge clk) begin
        rd_pipe[0] <= sram_rd_en ? word_at(sram_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        rd_pipe[1] <= rd_pipe[0];
    end
    assign sram_rd_data = rd_pipe[L-1];

    // Scoreboard: match every SRAM access against the queued expectations
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sram_rd_en === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexpected: got addr %h at cycle %0d, want no read", sram_rd_addr, cyc - start_cyc);
                end else begin
                    mon_rd_e = rd_q.pop_front();
                    if (sram_rd_addr !== mon_rd_e.addr || cyc != start_cyc + mon_rd_e.offset) begin
                        errors++;
                        $display("FAIL rd_access: got addr %h at T+%0d, want addr %h at T+%0d",
                                 sram_rd_addr, cyc - start_cyc, mon_rd_e.addr, mon_rd_e.offset);
                    end
                end
            end
            if (sram_wr_en === 1'b1) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got addr %h at cycle %0d, want no write", sram_wr_addr, cyc - start_cyc);
                end else begin
                    mon_wr_e = wr_q.pop_front();
                    if (sram_wr_addr !== mon_wr_e.addr || sram_wr_data !== mon_wr_e.data ||
                        cyc != start_cyc + mon_wr_e.offset) begin
                        errors++;
                        $display("FAIL wr_access: got addr %h data %h at T+%0d, want addr %h data %h at T+%0d",
                                 sram_wr_addr, sram_wr_data, cyc - start_cyc,
                                 mon_wr_e.addr, mon_wr_e.data, mon_wr_e.offset);
                    end
                end
            end
        end
    end

    task automatic push_expect(input logic [9:0] src, input logic [9:0] dst, input int n);
        logic [9:0] s;
        logic [9:0] d;
        for (int i = 0; i < n; i++) begin
            s = src + 10'(i);
            d = dst + 10'(i);
            rd_q.push_back('{s, 64'd0, i + 1});
            wr_q.push_back('{d, word_at(s), i + 1 + L});
        end
    endtask

    task automatic axi_write(input logic [39:0] addr, input logic [63:0] data, input bit is_start);
        int n;
        bit hs_ok;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (axi.awready !== 1'b1 && n < 50);
        hs_ok = (axi.awready === 1'b1) && (axi.wready === 1'b1);
        if (hs_ok && is_start) start_cyc = cyc;
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!hs_ok || axi.bvalid !== 1'b1 || axi.bresp !== 2'b00) begin
            errors++;
            $display("FAIL axi_write %h: got handshake %0b bvalid %b bresp %b, want 1 1 00",
                     addr, hs_ok, axi.bvalid, axi.bresp);
        end
    endtask

    task automatic axi_read(input logic [39:0] addr, output logic [63:0] data);
        int n;
        bit hs_ok;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (axi.arready !== 1'b1 && n < 50);
        hs_ok = (axi.arready === 1'b1);
        @(negedge clk);
        axi.arvalid = 1'b0;
        data = axi.rdata;
        checks++;
        if (!hs_ok || axi.rvalid !== 1'b1 || axi.rresp !== 2'b00) begin
            errors++;
            $display("FAIL axi_read %h: got handshake %0b rvalid %b rresp %b, want 1 1 00",
                     addr, hs_ok, axi.rvalid, axi.rresp);
        end
    endtask

    task automatic wait_done(output int c);
        int n = 0;
        while (irq !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        c = (irq === 1'b1) ? cyc : -1;
    endtask

    task automatic run_copy(input logic [9:0] src, input logic [9:0] dst, input int len,
                            input int exp_done, input int exp_cycles);
        int c;
        logic [63:0] d;
        axi_write(A_STATUS, 64'h2, 1'b0);
        axi_write(A_SRC, 64'(src), 1'b0);
        axi_write(A_DST, 64'(dst), 1'b0);
        axi_write(A_LEN, 64'(len), 1'b0);
        push_expect(src, dst, len);
        axi_write(A_CTL, 64'h1, 1'b1);
        wait_done(c);
        checks++;
        if (c != start_cyc + exp_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_timing len=%0d: got done at T+%0d busy %b, want T+%0d busy 0",
                     len, c - start_cyc, busy, exp_done);
        end
        repeat (L + 1) @(negedge clk);
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_access len=%0d: got %0d reads %0d writes outstanding, want 0 0",
                     len, rd_q.size(), wr_q.size());
        end
        axi_read(A_CYCLES, d);
        checks++;
        if (d !== 64'(exp_cycles)) begin
            errors++;
            $display("FAIL cycles len=%0d: got %0d want %0d", len, d, exp_cycles);
        end
        axi_read(A_STATUS, d);
        checks++;
        if (d !== 64'h2 || irq !== 1'b1) begin
            errors++;
            $display("FAIL status_done len=%0d: got %h irq %b, want 2 irq 1", len, d, irq);
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, irq, sram_rd_en, sram_wr_en, axi.awready, axi.wready,
             axi.arready, axi.bvalid, axi.rvalid} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {busy, irq, sram_rd_en, sram_wr_en, axi.awready, axi.wready,
                      axi.arready, axi.bvalid, axi.rvalid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(A_ID, d);
        checks++;
        if (d !== 64'h5352_4D32_5345_5130) begin
            errors++;
            $display("FAIL id: got %h want 53524d3253455130", d);
        end
        axi_read(A_STATUS, d);
        checks++;
        if (d !== 64'h0) begin
            errors++;
            $display("FAIL status_reset: got %h want 0", d);
        end
        axi_read(40'h38, d);
        checks++;
        if (d !== 64'h0) begin
            errors++;
            $display("FAIL unmapped_read: got %h want 0", d);
        end
    endtask

    task automatic test_basic();
        run_copy(10'h010, 10'h200, 8, 11, 10);
    endtask

    task automatic test_wrap();
        run_copy(10'h3FE, 10'h3FF, 4, 7, 6);
    endtask

    task automatic test_len_zero();
        run_copy(10'h100, 10'h180, 0, 1, 0);
    endtask

    task automatic test_status_clear();
        logic [63:0] d;
        axi_write(A_STATUS, 64'h2, 1'b0);
        axi_read(A_STATUS, d);
        checks++;
        if (d !== 64'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL status_clear: got %h irq %b, want 0 irq 0", d, irq);
        end
    endtask

    task automatic test_busy_writes();
        int c;
        logic [63:0] d;
        axi_write(A_STATUS, 64'h2, 1'b0);
        axi_write(A_SRC, 64'h020, 1'b0);
        axi_write(A_DST, 64'h300, 1'b0);
        axi_write(A_LEN, 64'd40, 1'b0);
        push_expect(10'h020, 10'h300, 40);
        axi_write(A_CTL, 64'h1, 1'b1);
        axi_write(A_LEN, 64'd3, 1'b0);
        axi_write(A_SRC, 64'h155, 1'b0);
        axi_write(A_CTL, 64'h1, 1'b0);
        wait_done(c);
        checks++;
        if (c != start_cyc + 43) begin
            errors++;
            $display("FAIL busy_done_timing: got T+%0d want T+43", c - start_cyc);
        end
        repeat (L + 1) @(negedge clk);
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL busy_missing_access: got %0d reads %0d writes outstanding, want 0 0",
                     rd_q.size(), wr_q.size());
        end
        axi_read(A_LEN, d);
        checks++;
        if (d !== 64'd40) begin
            errors++;
            $display("FAIL len_locked: got %0d want 40", d);
        end
        axi_read(A_SRC, d);
        checks++;
        if (d !== 64'h020) begin
            errors++;
            $display("FAIL src_locked: got %h want 020", d);
        end
        axi_read(A_CYCLES, d);
        checks++;
        if (d !== 64'd42) begin
            errors++;
            $display("FAIL busy_cycles: got %0d want 42", d);
        end
    endtask

    task automatic test_abort();
        int c;
        logic [63:0] d;
        axi_write(A_STATUS, 64'h2, 1'b0);
        axi_write(A_SRC, 64'h040, 1'b0);
        axi_write(A_DST, 64'h080, 1'b0);
        axi_write(A_LEN, 64'd100, 1'b0);
        push_expect(10'h040, 10'h080, 5);
        axi_write(A_CTL, 64'h1, 1'b1);
        while (cyc < start_cyc + 4) @(negedge clk);
        // Abort handshake lands in cycle T+5, right after the fifth read issues
        axi_write(A_CTL, 64'h3, 1'b0);
        wait_done(c);
        checks++;
        if (c != start_cyc + 5 + L + 1) begin
            errors++;
            $display("FAIL abort_done_timing: got T+%0d want T+%0d", c - start_cyc, 5 + L + 1);
        end
        repeat (L + 1) @(negedge clk);
        checks++;
        if (rd_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL abort_missing_access: got %0d reads %0d writes outstanding, want 0 0",
                     rd_q.size(), wr_q.size());
        end
        axi_read(A_CYCLES, d);
        checks++;
        if (d !== 64'd7) begin
            errors++;
            $display("FAIL abort_cycles: got %0d want 7", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        int n_act;
        axi_write(A_STATUS, 64'h2, 1'b0);
        axi_write(A_SRC, 64'h010, 1'b0);
        axi_write(A_DST, 64'h200, 1'b0);
        axi_write(A_LEN, 64'd8, 1'b0);
        push_expect(10'h010, 10'h200, 8);
        axi_write(A_CTL, 64'h1, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sram_rd_en, sram_wr_en, busy, irq} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b want 0000", {sram_rd_en, sram_wr_en, busy, irq});
        end
        rd_q.delete();
        wr_q.delete();
        n_act = 0;
        repeat (3) begin
            @(negedge clk);
            if (sram_wr_en !== 1'b0 || sram_rd_en !== 1'b0) n_act++;
        end
        checks++;
        if (n_act != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", n_act);
        end
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(A_LEN, d);
        checks++;
        if (d !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_len: got %0d want 0", d);
        end
        run_copy(10'h010, 10'h200, 8, 11, 10);
    endtask

    initial begin
        rst_n       = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = 40'd0;
        axi.awprot  = 3'd0;
        axi.wvalid  = 1'b0;
        axi.wdata   = 64'd0;
        axi.wstrb   = 8'hFF;
        axi.bready  = 1'b1;
        axi.arvalid = 1'b0;
        axi.araddr  = 40'd0;
        axi.arprot  = 3'd0;
        axi.rready  = 1'b1;

        test_reset();
        test_basic();
        test_status_clear();
        test_wrap();
        test_len_zero();
        test_busy_writes();
        test_abort();
        test_reset_mid();
        test_status_clear();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
